if_id_prefetch: RTL

Parametrised successor to the IF/ID stage of the FemtoRV32 pipeline. Combines the PC register, an instruction-memory request port, a DEPTH-entry prefetch FIFO of {pc, instr} pairs, and the IF/ID output register. Supports a load-use stall from the hazard unit and a branch/jump redirect from EX/MEM. Output feeds the ID stage (decode/register file).

---
 rtl/if_id_prefetch.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/if_id_prefetch.sv
// IF/ID stage with PC register, instruction-memory request port, DEPTH-entry prefetch FIFO and IF/ID register.
// Optional saturating stall/bubble counters are built when IFID_PERF_EN is defined.
module if_id_prefetch #(
   parameter int               XLEN     = 32,
   parameter int               DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_rvalid,
   input  logic              stall,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              ifid_valid,
   output logic [XLEN-1:0]   ifid_pc,
   output logic [31:0]       ifid_instr,
   output logic [XLEN-1:0]   ifid_pc_plus4,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_bubble_cnt
);

   localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int             CW       = AW + 1;
   localparam logic [31:0]    NOP      = 32'h0000_0013;
   localparam logic [CW-1:0]  LP_DEPTH = CW'(DEPTH);

   // fetch stage (p0): PC and request
   logic [XLEN-1:0]  r_pc_p0;

   // response stage (p1): request expected to answer this cycle
   logic             r_vld_p1;
   logic [XLEN-1:0]  r_pc_p1;
   logic             r_squash_p1;

   logic [XLEN-1:0]  r_fifo_pc    [DEPTH];
   logic [31:0]      r_fifo_instr [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   // IF/ID stage (p2)
   logic             r_ifid_vld_p2;
   logic [XLEN-1:0]  r_ifid_pc_p2;
   logic [31:0]      r_ifid_instr_p2;

   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   logic             w_req;
   logic [CW:0]      w_reserved;
   logic             w_unused;

   assign w_empty = (r_count == '0);
   assign w_pop   = ~redirect & ~stall & ~w_empty;
   assign w_push  = imem_rvalid & r_vld_p1 & ~r_squash_p1 & ~redirect;

   // A new request is allowed only if a slot is still free after counting the
   // response already on its way, so the FIFO can never overflow.
   assign w_reserved = {1'b0, r_count} + (CW+1)'(r_vld_p1) - (CW+1)'(w_pop);
   assign w_req      = rst & ~redirect & (w_reserved < {1'b0, LP_DEPTH});

   assign imem_req      = w_req;
   assign imem_addr     = r_pc_p0;
   assign ifid_valid    = r_ifid_vld_p2;
   assign ifid_pc       = r_ifid_pc_p2;
   assign ifid_instr    = r_ifid_instr_p2;
   assign ifid_pc_plus4 = r_ifid_pc_p2 + XLEN'(4);
   assign w_unused      = ^redirect_pc[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc_p0         <= RESET_PC;
         r_vld_p1        <= 1'b0;
         r_squash_p1     <= 1'b0;
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_count         <= '0;
         r_ifid_vld_p2   <= 1'b0;
         r_ifid_pc_p2    <= '0;
         r_ifid_instr_p2 <= NOP;
      end else begin
         r_vld_p1    <= w_req;
         r_squash_p1 <= redirect & r_vld_p1;
         if (redirect) begin
            r_pc_p0  <= {redirect_pc[XLEN-1:2], 2'b00};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_req)  r_pc_p0  <= r_pc_p0 + XLEN'(4);
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end

         if (redirect) begin
            r_ifid_vld_p2   <= 1'b0;
            r_ifid_instr_p2 <= NOP;
         end else if (!stall) begin
            if (w_pop) begin
               r_ifid_vld_p2   <= 1'b1;
               r_ifid_pc_p2    <= r_fifo_pc[r_rd_ptr];
               r_ifid_instr_p2 <= r_fifo_instr[r_rd_ptr];
            end else begin
               r_ifid_vld_p2   <= 1'b0;
               r_ifid_instr_p2 <= NOP;
            end
         end
      end
   end

   // FIFO storage and request PC carry no reset; occupancy and r_vld_p1 qualify them.
   always_ff @(posedge clk) begin
      r_pc_p1 <= r_pc_p0;
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]    <= r_pc_p1;
         r_fifo_instr[r_wr_ptr] <= imem_rdata;
      end
   end

`ifdef IFID_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_bubble;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_stall  <= '0;
         r_perf_bubble <= '0;
      end else begin
         if (stall & ~redirect)            r_perf_stall  <= sat_inc(r_perf_stall);
         if (~redirect & ~stall & w_empty) r_perf_bubble <= sat_inc(r_perf_bubble);
      end
   end

   assign perf_stall_cnt  = r_perf_stall;
   assign perf_bubble_cnt = r_perf_bubble;
`else
   assign perf_stall_cnt  = '0;
   assign perf_bubble_cnt = '0;
`endif

endmodule
